// File: rtl/debounce_pkg.sv
// Shared defaults and width helpers for the debounce bank and its channels.
package debounce_pkg;

  localparam int unsigned DEF_N_CH         = 4;
  localparam int unsigned DEF_TICK_DIV     = 50000;
  localparam int unsigned DEF_STABLE_TICKS = 4;

  // Prescaler width: enough bits to hold 0..tick_div-1.
  function automatic int unsigned div_cnt_w(input int unsigned tick_div);
    return $clog2(tick_div);
  endfunction

  // Stable counter width: enough bits to hold 0..stable_ticks.
  function automatic int unsigned stable_cnt_w(input int unsigned stable_ticks);
    return $clog2(stable_ticks + 1);
  endfunction

endpackage

// File: rtl/debounce_bank_if.sv
// Signal bundle between the debounce bank and its user.
// No handshake: en/btn_in are levels from the user; btn_db is a level, tick/rise/fall are one-cycle strobes.
interface debounce_bank_if
  import debounce_pkg::*;
#(
  parameter int N_CH = DEF_N_CH
);

  logic            en;
  logic [N_CH-1:0] btn_in;
  logic [N_CH-1:0] btn_db;
  logic [N_CH-1:0] rise_pulse;
  logic [N_CH-1:0] fall_pulse;
  logic            tick;

  modport master (
    output en, btn_in,
    input  btn_db, rise_pulse, fall_pulse, tick
  );

  modport slave (
    input  en, btn_in,
    output btn_db, rise_pulse, fall_pulse, tick
  );

endinterface

// File: rtl/debounce_channel.sv
// One debounced input: 2-flop synchronizer, tick-gated stability counter, edge strobes.
module debounce_channel
  import debounce_pkg::*;
#(
  parameter int STABLE_TICKS = DEF_STABLE_TICKS
) (
  input  logic clk,
  input  logic rst_a_p,
  input  logic tick_i,
  input  logic btn_i,
  output logic db_o,
  output logic rise_o,
  output logic fall_o
);

  localparam int CNT_W = stable_cnt_w(STABLE_TICKS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_TICKS - 1);

  logic             sync1_q;
  logic             sync2_q;
  logic [CNT_W-1:0] cnt_q,  cnt_d;
  logic             db_q,   db_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;

  // A single matching sample wipes all accumulated credit.
  always_comb begin
    cnt_d  = cnt_q;
    db_d   = db_q;
    rise_d = 1'b0;
    fall_d = 1'b0;
    if (tick_i) begin
      if (sync2_q != db_q) begin
        if (cnt_q == CNT_LAST) begin
          cnt_d  = '0;
          db_d   = sync2_q;
          rise_d = sync2_q;
          fall_d = ~sync2_q;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end else begin
        cnt_d = '0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst_a_p) begin
    if (rst_a_p) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      cnt_q   <= '0;
      db_q    <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
      cnt_q   <= cnt_d;
      db_q    <= db_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign db_o   = db_q;
  assign rise_o = rise_q;
  assign fall_o = fall_q;

endmodule

// File: rtl/debounce_bank.sv
// Bank of N_CH debounced inputs sharing one sample-tick prescaler.
module debounce_bank
  import debounce_pkg::*;
#(
  parameter int N_CH         = DEF_N_CH,
  parameter int TICK_DIV     = DEF_TICK_DIV,
  parameter int STABLE_TICKS = DEF_STABLE_TICKS
) (
  input  logic                 clk,
  input  logic                 rst_a_p,
  debounce_bank_if.slave       bus
);

  localparam int DIV_W = div_cnt_w(TICK_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);

  logic [DIV_W-1:0] div_q, div_d;
  logic             tick_q, tick_d;

  // Disabled prescaler holds its count so a paused period resumes where it left off.
  always_comb begin
    div_d  = div_q;
    tick_d = 1'b0;
    if (bus.en) begin
      if (div_q == DIV_LAST) begin
        div_d  = '0;
        tick_d = 1'b1;
      end else begin
        div_d = div_q + DIV_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst_a_p) begin
    if (rst_a_p) begin
      div_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      div_q  <= div_d;
      tick_q <= tick_d;
    end
  end

  assign bus.tick = tick_q;

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    debounce_channel #(
      .STABLE_TICKS (STABLE_TICKS)
    ) u_ch (
      .clk     (clk),
      .rst_a_p (rst_a_p),
      .tick_i  (tick_q),
      .btn_i   (bus.btn_in[g]),
      .db_o    (bus.btn_db[g]),
      .rise_o  (bus.rise_pulse[g]),
      .fall_o  (bus.fall_pulse[g])
    );
  end

endmodule

// File: doc/debounce_bank.md
DEBOUNCE_BANK -- requirements
Module: debounce_bank

Interface
REQ-001 Parameter N_CH, default 4: number of independent input channels, 1..32.
REQ-002 Parameter TICK_DIV, default 50000: clock cycles per sample tick, 2..2^20.
REQ-003 Parameter STABLE_TICKS, default 4: consecutive differing samples needed to accept a new level, 1..255.
REQ-004 clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 rst_a_p  input  1  asynchronous, active-high reset.
REQ-006 en  input  1  prescaler enable; low freezes the tick counter and suppresses ticks.
REQ-007 btn_in  input  N_CH  raw asynchronous button/switch levels.
REQ-008 btn_db  output  N_CH  debounced level per channel, registered.
REQ-009 rise_pulse  output  N_CH  one-cycle strobe when btn_db goes 0->1.
REQ-010 fall_pulse  output  N_CH  one-cycle strobe when btn_db goes 1->0.
REQ-011 tick  output  1  one-cycle sample strobe, registered.

Function
REQ-012 Each btn_in bit SHALL pass through a 2-flop synchronizer; only the second-stage value (sync) is used downstream.
REQ-013 Prescaler counter SHALL be $clog2(TICK_DIV) bits wide, count 0..TICK_DIV-1 while en=1, and wrap to 0 after TICK_DIV-1.
REQ-014 tick SHALL be 1 for exactly the cycle following the edge where the counter wraps, giving a period of exactly TICK_DIV cycles with en held high.
REQ-015 With en=0, counter SHALL hold its value and tick SHALL be 0; on en returning high, counting SHALL resume from the held value.
REQ-016 Each channel SHALL own a stable counter of $clog2(STABLE_TICKS+1) bits, updated only in cycles where tick=1.
REQ-017 On a tick with sync != btn_db: if count == STABLE_TICKS-1, btn_db <= sync and count <= 0; otherwise count <= count+1.
REQ-018 On a tick with sync == btn_db, count SHALL clear to 0 (glitch rejection; no partial credit retained).
REQ-019 rise_pulse/fall_pulse SHALL be registered on the same edge that updates btn_db, high for exactly one cycle, never both high on one channel.
REQ-020 Channels SHALL be fully independent; simultaneous transitions on several channels SHALL all be accepted on the same tick.
REQ-021 Minimum acceptance latency from a clean btn_in step: 2 sync cycles plus STABLE_TICKS ticks; maximum adds one further TICK_DIV period.
REQ-022 STABLE_TICKS=1 SHALL accept a change on the first tick that samples the differing level.

Reset
REQ-023 rst_a_p high SHALL immediately clear synchronizers, prescaler, all stable counters, btn_db, rise_pulse, fall_pulse and tick to 0.
REQ-024 Reset asserted mid-count SHALL discard pending acceptance; after release, a held-high input SHALL require the full STABLE_TICKS again and produce a rise_pulse.
REQ-025 No output SHALL pulse in the first cycle after reset release.

Structure
REQ-026 Shared package/header debounce_pkg SHALL hold default values of N_CH, TICK_DIV, STABLE_TICKS and the width-derivation macros.
REQ-027 Per-channel logic (synchronizer, stable counter, edge strobes) SHALL be a sub-module debounce_channel instantiated N_CH times by a generate loop; prescaler stays in debounce_bank.

Verification (bench: N_CH=4, TICK_DIV=10, STABLE_TICKS=3)
REQ-028 en=1, no input activity for 100 cycles -> tick high exactly 10 times, spaced exactly 10 cycles, btn_db stays 4'b0000.
REQ-029 btn_in[0] 0->1 held -> btn_db[0]=1 on the third tick after sync, rise_pulse[0] high one cycle, other channels unchanged.
REQ-030 btn_in[1] high for 2 ticks then low (bounce) -> no change on btn_db[1], no pulses; counter restarts on next rise.
REQ-031 btn_in 4'b1111 then 4'b0000 each held 5 ticks -> all four rise on one tick, all four fall on one tick, fall_pulse=4'b1111 for one cycle.
REQ-032 en=0 for 25 cycles mid-count -> no ticks, btn_db frozen; after en=1 the next tick occurs after the remaining count only.
REQ-033 rst_a_p pulsed after 2 accepting ticks on btn_in[2] -> all outputs 0 immediately; with input still high, btn_db[2]=1 only after 3 further ticks.
